// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU constants: operand width, divider FSM encodings, step count
package alu_pkg;

  localparam int WIDTH = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int DIV_STEPS = 2 * WIDTH;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
module div_step #(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic [WIDTH:0]   prem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   prem_next,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  // One guard bit above the shifted remainder makes the trial sign a plain borrow.
  always_comb begin
    shifted   = {prem, dvd_msb};
    trial     = shifted - {2'b00, dvs};
    q_bit     = ~trial[WIDTH+1];
    prem_next = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/div_samp.sv
// rtl/div_samp.sv - sequential restoring divider, 2*WIDTH-bit dividend by WIDTH-bit divisor
module div_samp
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2*WIDTH-1:0] Dvd_in,
  input  logic [WIDTH-1:0]   Dvs_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] Quo,
  output logic [WIDTH-1:0]   Rem,
  output logic               Dz
);

  localparam int            CW   = $clog2(2 * WIDTH);
  localparam logic [CW-1:0] LAST = CW'(2 * WIDTH - 1);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] dvd_sr;
  logic [WIDTH-1:0]   dvs_r;
  logic [WIDTH:0]     prem;
  logic [WIDTH:0]     prem_next;
  logic               q_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .prem      (prem),
    .dvd_msb   (dvd_sr[2*WIDTH-1]),
    .dvs       (dvs_r),
    .prem_next (prem_next),
    .q_bit     (q_bit)
  );

  // Quotient bits shift into the dividend register as dividend bits shift out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      dvd_sr <= '0;
      dvs_r  <= '0;
      prem   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      Quo    <= '0;
      Rem    <= '0;
      Dz     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            dvd_sr <= Dvd_in;
            dvs_r  <= Dvs_in;
            prem   <= '0;
            cnt    <= '0;
            if (Dvs_in == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
              Quo   <= '1;
              Rem   <= '0;
              Dz    <= 1'b1;
            end else begin
              state <= S_RUN;
              busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          dvd_sr <= {dvd_sr[2*WIDTH-2:0], q_bit};
          prem   <= prem_next;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            Quo   <= {dvd_sr[2*WIDTH-2:0], q_bit};
            Rem   <= prem_next[WIDTH-1:0];
            Dz    <= 1'b0;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
